pipeline_hazard_scoreboard: RTL and testbench
=============================================

# pipeline_hazard_scoreboard

Parametrised hazard and flush controller for the in-order integer pipeline (fetch → decoded → reg_access → ALU → post-ALU → writeback). It replaces per-stage destination comparison with a per-register countdown scoreboard, so write-back latency is configurable. It also adds a jump-flush state machine and a saturating stall-cycle performance counter. The block drives the latch enables of fetch, decoded and reg_access, plus the jump-control enable.

## Interface
- REG_W, 5, register address width; the register file has 2^REG_W entries, and x0 is hardwired zero.
- FLAG_W, 17, width of decoded flag vectors.
- WR_BIT, 0, flag bit meaning "instruction writes rd".
- JALR_BIT, 10, flag bit for JALR.
- BR_BIT, 12, flag bit for conditional branch.
- WB_LAT, 3, cycles from reg_access issue until the result is readable from the register file; range 1..15.
- FLUSH_CYCLES, 2, cycles of flush after a taken jump; range 1..7.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- decoded_valid  in  1  decoded stage holds a real instruction.
- decoded_rs1, decoded_rs2  in  REG_W  decoded-stage sources.
- reg_access_valid  in  1  reg_access stage holds a real instruction.
- reg_access_flags  in  FLAG_W  reg_access-stage flags.
- reg_access_rs1, reg_access_rs2, reg_access_rd  in  REG_W  reg_access-stage operands.
- jump_taken  in  1  jump/branch in reg_access resolved as taken this cycle.
- fetch_en, decoded_latch_en, reg_access_latch_en, alu_latch_en  out  1  stage advance enables.
- flush  out  1  decoded and reg_access load bubbles this cycle.
- jmpctrl_en  out  1  enable jump control unit.
- pending  out  2^REG_W  scoreboard busy bits; bit 0 is always 0.
- stall_cycles  out  CNT_W  saturating count of cycles with fetch_en=0.

## Operation
- **Scoreboard.**
  - Each register r≥1 has a countdown cnt[r] of width clog2(WB_LAT+1).
  - pending[r] = (cnt[r]≠0).
  - Every cycle, each nonzero cnt decrements by 1.
  - issue = reg_access_valid & ~ra_blocked & ~flush.
  - If issue & reg_access_flags[WR_BIT] & reg_access_rd≠0, then cnt[rd] loads WB_LAT. The load overrides the decrement of the same entry.
  - No instruction with rd=0 ever sets the scoreboard.
- **Hazards.** A source equal to 0 never causes a hazard.
  - ra_blocked = reg_access_valid & (pending[reg_access_rs1] | pending[reg_access_rs2]).
  - dec_blocked = decoded_valid & (pending[decoded_rs1] | pending[decoded_rs2] | raw_ra).
  - raw_ra = reg_access_valid & reg_access_flags[WR_BIT] & reg_access_rd≠0 & (decoded_rs1 or decoded_rs2 equal to reg_access_rd).
- **Enables** (combinational, when flush=0):
  - fetch_en = ~dec_blocked & ~ra_blocked.
  - decoded_latch_en = fetch_en.
  - reg_access_latch_en = ~ra_blocked.
  - alu_latch_en = 1 always.
  - When reg_access stalls but decoded does not, reg_access holds and decoded also holds (ra_blocked propagates upstream).
- **Flush FSM.** States are IDLE and FLUSH, with a counter fc.
  - IDLE: if jump_taken & reg_access_valid & ~ra_blocked, go to FLUSH with fc=FLUSH_CYCLES-1.
  - FLUSH: if fc=0 go to IDLE, else fc decrements.
  - jump_taken is ignored while in FLUSH.
  - flush=1 whenever the state is FLUSH.
  - During flush, all latch enables are 1, hazards are ignored, and issue is suppressed, so bubbles never set the scoreboard.
- jmpctrl_en = reg_access_valid & (reg_access_flags[JALR_BIT] | reg_access_flags[BR_BIT]) & ~ra_blocked & ~flush.
- **stall_cycles** increments when fetch_en=0 and rst=0. It holds at 2^CNT_W−1.
- **Reset.** While rst=1:
  - all cnt clear, the FSM goes to IDLE, and stall_cycles clears to 0;
  - outputs are forced to fetch_en=decoded_latch_en=reg_access_latch_en=alu_latch_en=1, flush=1, jmpctrl_en=0 and pending=0.
  - Reset arriving in mid-flush or mid-stall abandons that state fully.

## Timing
- All hazard and enable outputs are combinational from the current inputs and registered state. The same-cycle inputs-to-output path has no register.
- For a producer issuing at edge N, a dependent instruction in reg_access stalls for WB_LAT cycles and issues at edge N+WB_LAT+1.
- flush is first high in the cycle after the edge that sampled the taken jump. It stays high for exactly FLUSH_CYCLES cycles.
- The stall counter updates at the edge that ends the stalled cycle.
- pending reflects the registered cnt values, so it does not include the issue happening in the current cycle.

## Test plan
- **Back-to-back dependency:** `add x5` issues at edge 10, and the next instruction reads x5 in reg_access. Required: reg_access_latch_en=0 and fetch_en=0 for 3 cycles; issue at edge 14; stall_cycles=3.
- **x0 destination:** a writer with rd=0 issues, followed by a reader of x0. Required: no stall; pending stays 0.
- **Same rd reissue:** x7 is written at edge 5 and again at edge 6 by an independent stream. Required: pending[7] is high from edge 5 through edge 9, and drops after edge 9.
- **Taken branch:** jump_taken=1 at edge 20. Required: flush=1 in the cycles after edges 20 and 21, 0 after edge 22; a writer in the flushed slots does not set its rd bit. A second jump_taken asserted during flush has no effect.
- **Decoded-vs-reg_access RAW:** reg_access holds a writer of x3 (not yet issued), and decoded reads x3. Required: fetch_en=0 and decoded_latch_en=0 while reg_access_latch_en=1.
- **Reset mid-operation:** assert rst during a stall with pending[5]=1, and separately during flush. Required: the next cycle after rst is released has pending=0, flush=0, all enables 1, and stall_cycles=0.

Source files
------------

// File: rtl/pipeline_hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_scoreboard_if
//
// Bundles the hazard controller's pipeline-facing signals.
//   master : pipeline side. It drives the stage status and sources, and reads
//            the enables.
//   slave  : hazard controller. It reads the stage status and drives the
//            enables, the flush, the scoreboard view and the stall counter.
//
// Pipeline -> controller:
//   decoded_valid, decoded_rs1, decoded_rs2
//   reg_access_valid, reg_access_flags, reg_access_rs1/rs2/rd, jump_taken
// Controller -> pipeline:
//   fetch_en, decoded_latch_en, reg_access_latch_en, alu_latch_en
//   flush, jmpctrl_en, pending[2^REG_W], stall_cycles[CNT_W]
// -----------------------------------------------------------------------------
interface pipeline_hazard_scoreboard_if #(
  parameter int REG_W  = 5,
  parameter int FLAG_W = 17,
  parameter int CNT_W  = 16
);
  logic                    decoded_valid;
  logic [REG_W-1:0]        decoded_rs1;
  logic [REG_W-1:0]        decoded_rs2;
  logic                    reg_access_valid;
  logic [FLAG_W-1:0]       reg_access_flags;
  logic [REG_W-1:0]        reg_access_rs1;
  logic [REG_W-1:0]        reg_access_rs2;
  logic [REG_W-1:0]        reg_access_rd;
  logic                    jump_taken;

  logic                    fetch_en;
  logic                    decoded_latch_en;
  logic                    reg_access_latch_en;
  logic                    alu_latch_en;
  logic                    flush;
  logic                    jmpctrl_en;
  logic [(1<<REG_W)-1:0]   pending;
  logic [CNT_W-1:0]        stall_cycles;

  modport master (
    output decoded_valid, decoded_rs1, decoded_rs2,
    output reg_access_valid, reg_access_flags,
    output reg_access_rs1, reg_access_rs2, reg_access_rd, jump_taken,
    input  fetch_en, decoded_latch_en, reg_access_latch_en, alu_latch_en,
    input  flush, jmpctrl_en, pending, stall_cycles
  );

  modport slave (
    input  decoded_valid, decoded_rs1, decoded_rs2,
    input  reg_access_valid, reg_access_flags,
    input  reg_access_rs1, reg_access_rs2, reg_access_rd, jump_taken,
    output fetch_en, decoded_latch_en, reg_access_latch_en, alu_latch_en,
    output flush, jmpctrl_en, pending, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_scoreboard
//
// Hazard and flush controller for the in-order integer pipeline.
// Each register has a countdown. The countdown is loaded when a writer issues
// from reg_access and stays nonzero until the result can be read from the
// register file. A small FSM inserts bubbles after a taken jump, and a
// saturating counter records the cycles in which fetch was stalled.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   hz   : pipeline_hazard_scoreboard_if.slave. It carries the stage status
//          in, and the enables, flush, pending and stall_cycles out.
// -----------------------------------------------------------------------------
module pipeline_hazard_scoreboard #(
  parameter int REG_W        = 5,
  parameter int FLAG_W       = 17,
  parameter int WR_BIT       = 0,
  parameter int JALR_BIT     = 10,
  parameter int BR_BIT       = 12,
  parameter int WB_LAT       = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                        clk,
  input logic                        rst,
  pipeline_hazard_scoreboard_if.slave hz
);

  localparam int NREG = 1 << REG_W;
  localparam int SB_W = $clog2(WB_LAT + 1);
  localparam int FC_W = 3;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic [SB_W-1:0]   cnt_q [NREG];
  logic [SB_W-1:0]   cnt_d [NREG];
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic [NREG-1:0]   busy;
  logic              in_flush;
  logic              ra_writes;
  logic              ra_blocked;
  logic              raw_ra;
  logic              dec_blocked;
  logic              issue;

  logic              fetch_en_o;
  logic              decoded_latch_en_o;
  logic              reg_access_latch_en_o;
  logic              alu_latch_en_o;
  logic              flush_o;
  logic              jmpctrl_en_o;
  logic [NREG-1:0]   pending_o;

  // Busy view of the scoreboard. x0 is never busy, so a zero source never
  // produces a hazard.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  // Hazard detection. raw_ra covers a writer that still sits in reg_access
  // and has not yet reached the scoreboard.
  always_comb begin
    in_flush    = (state_q == FLUSH);
    ra_writes   = hz.reg_access_valid & hz.reg_access_flags[WR_BIT] &
                  (hz.reg_access_rd != '0);
    ra_blocked  = hz.reg_access_valid &
                  (busy[hz.reg_access_rs1] | busy[hz.reg_access_rs2]);
    raw_ra      = ra_writes & ((hz.decoded_rs1 == hz.reg_access_rd) |
                               (hz.decoded_rs2 == hz.reg_access_rd));
    dec_blocked = hz.decoded_valid &
                  (busy[hz.decoded_rs1] | busy[hz.decoded_rs2] | raw_ra);
    issue       = hz.reg_access_valid & ~ra_blocked & ~in_flush;
  end

  // Scoreboard next state. Every live countdown ticks down. A fresh issue to
  // the same register restarts it at the full latency.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - 1'b1;
      if (issue && ra_writes && (hz.reg_access_rd == REG_W'(r))) begin
        cnt_d[r] = SB_W'(WB_LAT);
      end
    end
    cnt_d[0] = '0;
  end

  // Flush FSM next state. fc counts the remaining flush cycles after the
  // current one. A jump seen while already flushing is ignored.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    unique case (state_q)
      IDLE: begin
        if (hz.jump_taken && hz.reg_access_valid && !ra_blocked) begin
          state_d = FLUSH;
          fc_d    = FC_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (fc_q == '0) begin
          state_d = IDLE;
        end else begin
          fc_d = fc_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode. Reset forces a known "everything open, flushing" picture.
  // A flush opens every latch so that bubbles replace the wrong-path work.
  always_comb begin
    fetch_en_o            = 1'b1;
    decoded_latch_en_o    = 1'b1;
    reg_access_latch_en_o = 1'b1;
    alu_latch_en_o        = 1'b1;
    flush_o               = 1'b0;
    jmpctrl_en_o          = 1'b0;
    pending_o             = busy;
    if (rst) begin
      flush_o   = 1'b1;
      pending_o = '0;
    end else if (in_flush) begin
      flush_o = 1'b1;
    end else begin
      fetch_en_o            = ~dec_blocked & ~ra_blocked;
      decoded_latch_en_o    = ~dec_blocked & ~ra_blocked;
      reg_access_latch_en_o = ~ra_blocked;
      jmpctrl_en_o          = hz.reg_access_valid & ~ra_blocked &
                              (hz.reg_access_flags[JALR_BIT] |
                               hz.reg_access_flags[BR_BIT]);
    end
  end

  // The stall counter saturates instead of wrapping.
  always_comb begin
    stall_d = stall_q;
    if (!fetch_en_o && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  // Scoreboard and stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      stall_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_q <= stall_d;
    end
  end

  assign hz.fetch_en            = fetch_en_o;
  assign hz.decoded_latch_en    = decoded_latch_en_o;
  assign hz.reg_access_latch_en = reg_access_latch_en_o;
  assign hz.alu_latch_en        = alu_latch_en_o;
  assign hz.flush               = flush_o;
  assign hz.jmpctrl_en          = jmpctrl_en_o;
  assign hz.pending             = pending_o;
  assign hz.stall_cycles        = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_scoreboard
//
// Directed bench for pipeline_hazard_scoreboard. A table of single-cycle
// vectors covers the combinational enables. Each vector can optionally start
// with one register already busy. Short hand-written sequences then cover the
// multi-cycle behaviour: back-to-back stall, x0, reissue, jump flush and reset.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_scoreboard;

  localparam logic [16:0] WR   = 17'h00001;
  localparam logic [16:0] JALR = 17'h00400;
  localparam logic [16:0] BR   = 17'h01000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass  = 0;
  int   ntotal = 0;

  always #5 clk = ~clk;

  pipeline_hazard_scoreboard_if #(.REG_W(5), .FLAG_W(17), .CNT_W(16)) hz ();

  pipeline_hazard_scoreboard #(
    .REG_W(5), .FLAG_W(17), .WR_BIT(0), .JALR_BIT(10), .BR_BIT(12),
    .WB_LAT(3), .FLUSH_CYCLES(2), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  typedef struct {
    logic [4:0]  pre_rd;
    logic        dv;
    logic [4:0]  drs1;
    logic [4:0]  drs2;
    logic        rav;
    logic [16:0] flags;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        exp_fetch;
    logic        exp_ra;
    logic        exp_jmp;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dv, input logic [4:0] drs1,
                               input logic [4:0] drs2, input logic rav,
                               input logic [16:0] flags, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic jt);
    hz.decoded_valid    = dv;
    hz.decoded_rs1      = drs1;
    hz.decoded_rs2      = drs2;
    hz.reg_access_valid = rav;
    hz.reg_access_flags = flags;
    hz.reg_access_rs1   = rs1;
    hz.reg_access_rs2   = rs2;
    hz.reg_access_rd    = rd;
    hz.jump_taken       = jt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    ntotal++;
    if (act === exp) begin
      npass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enables();
    return {26'd0, hz.fetch_en, hz.decoded_latch_en, hz.reg_access_latch_en,
            hz.alu_latch_en, hz.flush, hz.jmpctrl_en};
  endfunction

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends even if the clock stops advancing.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //        pre dv drs1 drs2 rav flags rs1 rs2 rd  fe ra jmp
    vecs[0]  = '{0, 0, 0, 0, 0, 17'd0, 0, 0, 0,  1, 1, 0};
    vecs[1]  = '{0, 1, 3, 0, 1, WR,    1, 2, 3,  0, 1, 0};
    vecs[2]  = '{0, 1, 0, 3, 1, WR,    1, 2, 3,  0, 1, 0};
    vecs[3]  = '{0, 1, 0, 0, 1, WR,    1, 2, 0,  1, 1, 0};
    vecs[4]  = '{0, 1, 3, 3, 1, 17'd0, 1, 2, 3,  1, 1, 0};
    vecs[5]  = '{0, 1, 3, 0, 0, WR,    1, 2, 3,  1, 1, 0};
    vecs[6]  = '{5, 0, 0, 0, 1, BR,    5, 0, 8,  0, 0, 0};
    vecs[7]  = '{5, 1, 1, 5, 0, 17'd0, 0, 0, 0,  0, 1, 0};
    vecs[8]  = '{5, 0, 5, 5, 0, 17'd0, 0, 0, 0,  1, 1, 0};
    vecs[9]  = '{0, 0, 0, 0, 1, BR,    1, 2, 0,  1, 1, 1};
    vecs[10] = '{0, 0, 0, 0, 1, JALR,  4, 4, 1,  1, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 0, JALR,  0, 0, 0,  1, 1, 0};
    vecs[12] = '{5, 0, 0, 0, 1, WR,    0, 5, 9,  0, 0, 0};

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("reset_enables", enables(), 32'b111110);
    checkOutput("reset_pending", hz.pending, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("post_reset_enables", enables(), 32'b111100);
    checkOutput("post_reset_stall", 32'(hz.stall_cycles), 32'd0);

    // Table-driven combinational checks.
    for (int i = 0; i < 13; i++) begin
      resetDut();
      if (vecs[i].pre_rd != 5'd0) begin
        applyStimulus(0, 0, 0, 1, WR, 0, 0, vecs[i].pre_rd, 0);
        tick();
      end
      applyStimulus(vecs[i].dv, vecs[i].drs1, vecs[i].drs2, vecs[i].rav,
                    vecs[i].flags, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, 0);
      #1;
      checkOutput($sformatf("vec%0d", i), enables(),
                  {26'd0, vecs[i].exp_fetch, vecs[i].exp_fetch, vecs[i].exp_ra,
                   1'b1, 1'b0, vecs[i].exp_jmp});
    end

    // Back-to-back dependency on x5. The reader stalls for 3 cycles.
    resetDut();
    applyStimulus(0, 0, 0, 1, WR, 1, 2, 5, 0);
    #1;
    checkOutput("b2b_producer_en", enables(), 32'b111100);
    tick();
    applyStimulus(0, 0, 0, 1, WR, 5, 0, 6, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("b2b_stall%0d", k), enables(), 32'b000100);
      tick();
    end
    checkOutput("b2b_release_en", enables(), 32'b111100);
    checkOutput("b2b_stall_cycles", 32'(hz.stall_cycles), 32'd3);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("b2b_pending_after_issue", hz.pending, 32'h0000_0040);

    // Writer to x0 followed by a reader of x0.
    resetDut();
    applyStimulus(0, 0, 0, 1, WR, 1, 2, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 1, WR, 0, 0, 4, 0);
    #1;
    checkOutput("x0_pending", hz.pending, 32'h0);
    checkOutput("x0_enables", enables(), 32'b111100);

    // x7 written on two consecutive edges. The busy window runs from the
    // second write.
    resetDut();
    applyStimulus(0, 0, 0, 1, WR, 1, 2, 7, 0);
    tick();
    checkOutput("reissue_e5", hz.pending, 32'h0000_0080);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("reissue_e6", hz.pending, 32'h0000_0080);
    tick();
    checkOutput("reissue_e7", hz.pending, 32'h0000_0080);
    tick();
    checkOutput("reissue_e8", hz.pending, 32'h0000_0080);
    tick();
    checkOutput("reissue_e9", hz.pending, 32'h0);

    // Taken branch: two flush cycles. A jump held during the flush is ignored.
    resetDut();
    applyStimulus(0, 0, 0, 1, BR, 1, 2, 0, 1);
    #1;
    checkOutput("br_jmpctrl", enables(), 32'b111101);
    tick();
    applyStimulus(1, 9, 0, 1, WR, 1, 2, 9, 1);
    #1;
    checkOutput("br_flush1", enables(), 32'b111110);
    tick();
    checkOutput("br_flush2", enables(), 32'b111110);
    checkOutput("br_flush2_pending", hz.pending, 32'h0);
    tick();
    checkOutput("br_after_flush", 32'(hz.flush), 32'd0);
    checkOutput("br_after_pending", hz.pending, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during a stall.
    resetDut();
    applyStimulus(0, 0, 0, 1, WR, 0, 0, 5, 0);
    tick();
    applyStimulus(1, 5, 0, 1, WR, 5, 0, 6, 0);
    #1;
    checkOutput("rst_stall_pending", hz.pending, 32'h0000_0020);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_forced_en", enables(), 32'b111110);
    checkOutput("rst_forced_pending", hz.pending, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_stall_release_en", enables(), 32'b111100);
    checkOutput("rst_stall_release_pending", hz.pending, 32'h0);
    checkOutput("rst_stall_release_count", 32'(hz.stall_cycles), 32'd0);

    // Reset during a flush.
    resetDut();
    applyStimulus(0, 0, 0, 1, BR, 1, 2, 0, 1);
    tick();
    checkOutput("rst_flush_active", 32'(hz.flush), 32'd1);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_flush_release_en", enables(), 32'b111100);
    checkOutput("rst_flush_release_count", 32'(hz.stall_cycles), 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
